// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and shift-kind types for the iterative ALU stage.
// ALU_ROTATE_EN enables ROL/ROR/RORI as shift-class opcodes.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_NONE  = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_ADDI  = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_SLTI  = 5'd6,
    ALU_SLTIU = 5'd7,
    ALU_AND   = 5'd8,
    ALU_OR    = 5'd9,
    ALU_XOR   = 5'd10,
    ALU_ANDI  = 5'd11,
    ALU_ORI   = 5'd12,
    ALU_XORI  = 5'd13,
    ALU_SLL   = 5'd14,
    ALU_SRL   = 5'd15,
    ALU_SRA   = 5'd16,
    ALU_SLLI  = 5'd17,
    ALU_SRLI  = 5'd18,
    ALU_SRAI  = 5'd19,
    ALU_ROL   = 5'd20,
    ALU_ROR   = 5'd21,
    ALU_RORI  = 5'd22
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_kind_e;

  // Rotates only count as shifts when the rotate hardware is built.
  function automatic logic is_shift_op(input alu_op_e op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLI, ALU_SRLI, ALU_SRAI: return 1'b1;
`ifdef ALU_ROTATE_EN
      ALU_ROL, ALU_ROR, ALU_RORI: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_op(input alu_op_e op);
    case (op)
      ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_ANDI, ALU_ORI, ALU_XORI,
      ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_RORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle until the count is spent.
// ALU_ROTATE_EN adds wrap-around fill for ROL/ROR.
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  shift_kind_e             kind,
  input  logic [XLEN-1:0]         a,
  input  logic [$clog2(XLEN)-1:0] amt,
  output logic                    done,
  output logic [XLEN-1:0]         result
);

  // Wide enough to hold SHIFT_STEP itself when SHIFT_STEP == XLEN.
  localparam int                CNT_W  = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0]  STEP_C = CNT_W'(SHIFT_STEP);
`ifdef ALU_ROTATE_EN
  localparam logic [CNT_W-1:0]  XLEN_C = CNT_W'(XLEN);
`endif

  logic              active;
  logic [XLEN-1:0]   acc;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  step_k;
  shift_kind_e       kind_q;

  assign step_k = (rem < STEP_C) ? rem : STEP_C;
  assign done   = active && (rem <= STEP_C);

  // result is the accumulator after this cycle's step; the top captures it on done.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
    result = acc;
    case (kind_q)
      SH_SLL:  result = acc << step_k;
      SH_SRL:  result = acc >> step_k;
      SH_SRA:  result = $unsigned($signed(acc) >>> step_k);
`ifdef ALU_ROTATE_EN
      SH_ROL:  result = (acc << step_k) | (acc >> (XLEN_C - step_k));
      SH_ROR:  result = (acc >> step_k) | (acc << (XLEN_C - step_k));
`endif
      default: result = acc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      active <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      kind_q <= SH_SLL;
    end else if (start) begin
      active <= 1'b1;
      acc    <= a;
      rem    <= CNT_W'(amt);
      kind_q <= kind;
    end else if (active) begin
      acc <= result;
      rem <= rem - step_k;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter_stage.sv
// Execute-stage ALU with valid/ready on both sides and an iterative shifter.
// ALU_ROTATE_EN adds ROL/ROR/RORI; otherwise those opcodes behave as undefined.
module alu_iter_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_wr_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wr_en,
  output logic            busy
);

  localparam int         SHAMT_W  = $clog2(XLEN);
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  logic [0:0]         state;
  alu_op_e            op;
  logic [XLEN-1:0]    opb;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    dec_result;
  logic               dec_wr_en;
  shift_kind_e        dec_kind;
  logic               accept;
  logic               start_shift;
  logic               sh_done;
  logic [XLEN-1:0]    sh_result;

  assign op    = alu_op_e'(in_op);
  assign opb   = is_imm_op(op) ? in_imm : in_b;
  assign shamt = opb[SHAMT_W-1:0];

  // in_ready must not depend on in_*, so decode never feeds back into it.
  assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(op) && (shamt != '0);
  assign busy        = (state == ST_SHIFT);

  // Shift-class ops present in_a here so a zero amount completes in one cycle.
  always_comb begin
    dec_result = '0;
    dec_wr_en  = in_wr_en;
    dec_kind   = SH_SLL;
    case (op)
      ALU_ADD, ALU_ADDI:  dec_result = in_a + opb;
      ALU_SUB:            dec_result = in_a - opb;
      ALU_SLT, ALU_SLTI:  dec_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(opb))};
      ALU_SLTU, ALU_SLTIU: dec_result = {{(XLEN-1){1'b0}}, (in_a < opb)};
      ALU_AND, ALU_ANDI:  dec_result = in_a & opb;
      ALU_OR, ALU_ORI:    dec_result = in_a | opb;
      ALU_XOR, ALU_XORI:  dec_result = in_a ^ opb;
      ALU_SLL, ALU_SLLI: begin
        dec_result = in_a;
        dec_kind   = SH_SLL;
      end
      ALU_SRL, ALU_SRLI: begin
        dec_result = in_a;
        dec_kind   = SH_SRL;
      end
      ALU_SRA, ALU_SRAI: begin
        dec_result = in_a;
        dec_kind   = SH_SRA;
      end
`ifdef ALU_ROTATE_EN
      ALU_ROL: begin
        dec_result = in_a;
        dec_kind   = SH_ROL;
      end
      ALU_ROR, ALU_RORI: begin
        dec_result = in_a;
        dec_kind   = SH_ROR;
      end
`endif
      default: dec_wr_en = 1'b0;  // ALU_NONE and undefined: zero result, no write
    endcase
  end

  alu_iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_shift),
    .kind    (dec_kind),
    .a       (in_a),
    .amt     (shamt),
    .done    (sh_done),
    .result  (sh_result)
  );

  // out_valid is always low in SHIFT, so completion never overwrites a pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wr_en  <= 1'b0;
    end else if (accept) begin
      out_rd    <= in_rd;
      out_wr_en <= dec_wr_en;
      if (start_shift) begin
        state     <= ST_SHIFT;
        out_valid <= 1'b0;
      end else begin
        out_valid  <= 1'b1;
        out_result <= dec_result;
      end
    end else if (busy) begin
      if (sh_done) begin
        state      <= ST_IDLE;
        out_valid  <= 1'b1;
        out_result <= sh_result;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
